// File: rtl/cache_req_sync_fifo_pkg.sv
// Shared types and defaults for the cache replacement request FIFO.
package cache_req_sync_fifo_pkg;

   // Request handshake state; 2-bit encoding shared with other replacement-path blocks.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PEND     = 2'd1,
      ACK      = 2'd2,
      WAIT_LOW = 2'd3
   } fsm_t;

   localparam int FREE_CYC_DEF = 3;

endpackage

// File: rtl/cache_sync2.sv
// Two-flop synchroniser for a single asynchronous level; resets to 0.
module cache_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops give metastability a full cycle to resolve.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/cache_req_sync_fifo.sv
// Consumes async drive/free/data requests, queues the data words and
// presents them on a valid/ready port to the replacement controller.
module cache_req_sync_fifo
   import cache_req_sync_fifo_pkg::*;
#(
   parameter int DATA_W   = 1,
   parameter int DEPTH    = 4,
   parameter int FREE_CYC = FREE_CYC_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_drive,
   input  logic [DATA_W-1:0]        i_data,
   output logic                     o_free,
   output logic                     o_valid,
   output logic [DATA_W-1:0]        o_data,
   input  logic                     i_ready,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int FW = (FREE_CYC > 1) ? $clog2(FREE_CYC) : 1;

   logic              drv_s, drv_q, rise;
   logic              full, pop, wr;
   fsm_t              state, state_nx;
   logic [FW-1:0]     free_cnt;
   logic [PW-1:0]     rd_ptr, wr_ptr;
   logic [DATA_W-1:0] mem [DEPTH];

   cache_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (i_drive),
      .q   (drv_s)
   );

   // Edge flop: a rise is one synchronised 0->1 transition of the drive level.
   always_ff @(posedge clk) begin
      if (rst) drv_q <= 1'b0;
      else     drv_q <= drv_s;
   end

   assign rise    = drv_s & ~drv_q;
   assign full    = (o_count == CW'(DEPTH));
   assign o_valid = (o_count != '0);
   assign pop     = o_valid & i_ready;
   assign o_data  = o_valid ? mem[rd_ptr] : '0;

   // Next-state and write decision; full is the registered occupancy, so a
   // pop while full lets a pending write through only on the following cycle.
   always_comb begin
      state_nx = state;
      wr       = 1'b0;
      case (state)
         IDLE: begin
            if (rise) begin
               if (!full) begin
                  wr       = 1'b1;
                  state_nx = ACK;
               end else begin
                  state_nx = PEND;
               end
            end
         end
         PEND: begin
            if (!full) begin
               wr       = 1'b1;
               state_nx = ACK;
            end
         end
         ACK:      if (free_cnt == '0) state_nx = WAIT_LOW;
         WAIT_LOW: if (!drv_s)         state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   // State register, free-pulse length counter and a glitch-free registered o_free.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         free_cnt <= '0;
         o_free   <= 1'b0;
      end else begin
         state  <= state_nx;
         o_free <= (state_nx == ACK);
         if (wr)
            free_cnt <= FW'(FREE_CYC - 1);
         else if (state == ACK && free_cnt != '0)
            free_cnt <= free_cnt - 1'b1;
      end
   end

   // Pointers wrap naturally at DEPTH (power of two); count carries the extra bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         o_count <= '0;
      end else begin
         if (wr)  wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({wr, pop})
            2'b10:   o_count <= o_count + 1'b1;
            2'b01:   o_count <= o_count - 1'b1;
            default: o_count <= o_count;
         endcase
      end
   end

   // Storage needs no reset: o_data is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= i_data;
   end

endmodule
